alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter feeding a shared 4-bit ALU (optional flags via ALU_ARBITER_FLAGS_EN)
module alu_arbiter #(
  parameter int FAIR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic       busy
`ifdef ALU_ARBITER_FLAGS_EN
  ,
  output logic       zero,
  output logic       cout
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op_r, op_n;
  logic [3:0] a_r, a_n, b_r, b_n, alu, result_n;
  logic win, win_n, last, last_n, pick1;
  logic gnt0_n, gnt1_n, done0_n, done1_n;
`ifdef ALU_ARBITER_FLAGS_EN
  logic [4:0] sum;
  logic carry, zero_n, cout_n;
`endif
  // a lone request always wins; on a tie, round-robin hands it to whoever did not win last
  assign pick1 = req1 && (!req0 || (FAIR != 0 && !last));
  assign busy = state != IDLE;
  // ALU on the latched operands
  always_comb begin
    alu = op_r == 3'd1 ? b_r - a_r :
          op_r == 3'd2 ? a_r - b_r :
          op_r == 3'd3 ? a_r + b_r :
          op_r == 3'd4 ? a_r ^ b_r :
          op_r == 3'd5 ? a_r | b_r :
          op_r == 3'd6 ? a_r & b_r :
          op_r == 3'd7 ? 4'hF : 4'h0;
`ifdef ALU_ARBITER_FLAGS_EN
    sum = {1'b0, a_r} + {1'b0, b_r};
    carry = op_r == 3'd3 ? sum[4] :
            op_r == 3'd1 ? b_r < a_r :
            op_r == 3'd2 ? a_r < b_r : 1'b0;
`endif
  end
  // next state, operand latch and one-cycle grant/done pulses
  always_comb begin
    state_n = state;
    op_n = op_r;
    a_n = a_r;
    b_n = b_r;
    win_n = win;
    last_n = last;
    result_n = result;
    gnt0_n = 1'b0;
    gnt1_n = 1'b0;
    done0_n = 1'b0;
    done1_n = 1'b0;
`ifdef ALU_ARBITER_FLAGS_EN
    zero_n = zero;
    cout_n = cout;
`endif
    case (state)
      IDLE: if (req0 || req1) begin
        state_n = EXEC;
        win_n = pick1;
        last_n = pick1;
        op_n = pick1 ? op1 : op0;
        a_n = pick1 ? a1 : a0;
        b_n = pick1 ? b1 : b0;
        gnt0_n = !pick1;
        gnt1_n = pick1;
      end
      EXEC: begin
        state_n = DONE;
        result_n = alu;
        done0_n = !win;
        done1_n = win;
`ifdef ALU_ARBITER_FLAGS_EN
        zero_n = alu == 4'h0;
        cout_n = carry;
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_r <= 3'd0;
      a_r <= 4'h0;
      b_r <= 4'h0;
      win <= 1'b0;
      last <= 1'b1;
      result <= 4'h0;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
`ifdef ALU_ARBITER_FLAGS_EN
      zero <= 1'b0;
      cout <= 1'b0;
`endif
    end else begin
      state <= state_n;
      op_r <= op_n;
      a_r <= a_n;
      b_r <= b_n;
      win <= win_n;
      last <= last_n;
      result <= result_n;
      gnt0 <= gnt0_n;
      gnt1 <= gnt1_n;
      done0 <= done0_n;
      done1 <= done1_n;
`ifdef ALU_ARBITER_FLAGS_EN
      zero <= zero_n;
      cout <= cout_n;
`endif
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tables, corner sequences and a randomized model check for alu_arbiter (FAIR=1 and FAIR=0 side by side)
module tb_alu_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = 3'd0, op1 = 3'd0;
  logic [3:0] a0 = 4'h0, b0 = 4'h0, a1 = 4'h0, b1 = 4'h0;
  logic f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_zero, f_cout;
  logic x_gnt0, x_gnt1, x_done0, x_done1, x_busy, x_zero, x_cout;
  logic [3:0] f_result, x_result;
  int n_tests = 0, n_fail = 0;
`ifdef ALU_ARBITER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
  assign f_zero = 1'b0;
  assign f_cout = 1'b0;
  assign x_zero = 1'b0;
  assign x_cout = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
    .result(f_result), .busy(f_busy)
`ifdef ALU_ARBITER_FLAGS_EN
    , .zero(f_zero), .cout(f_cout)
`endif
  );

  alu_arbiter #(.FAIR(0)) dut_fixed (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(x_gnt0), .gnt1(x_gnt1), .done0(x_done0), .done1(x_done1),
    .result(x_result), .busy(x_busy)
`ifdef ALU_ARBITER_FLAGS_EN
    , .zero(x_zero), .cout(x_cout)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int ref_res(input int op, input int a, input int b);
    case (op)
      1: return (b - a + 16) % 16;
      2: return (a - b + 16) % 16;
      3: return (a + b) % 16;
      4: return a ^ b;
      5: return a | b;
      6: return a & b;
      7: return 15;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_cout(input int op, input int a, input int b);
    return op == 3 ? (a + b) > 15 : op == 1 ? b < a : op == 2 ? a < b : 1'b0;
  endfunction

  typedef struct {
    bit sel;
    logic [2:0] op;
    logic [3:0] a, b, res;
    bit z, c;
  } vec_t;
  vec_t vecs[10];

  // reference model state per instance: k=0 round-robin, k=1 fixed priority
  int m_left[2], m_w[2], m_last[2], m_pend[2], m_res[2];
  bit m_pz[2], m_pc[2], m_z[2], m_c[2], m_g0[2], m_g1[2], m_d0[2], m_d1[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_last[k] = 1; m_res[k] = 0; m_z[k] = 0; m_c[k] = 0;
      m_g0[k] = 0; m_g1[k] = 0; m_d0[k] = 0; m_d1[k] = 0;
    end
  endtask

  task automatic model_step();
    int op, a, b;
    for (int k = 0; k < 2; k++) begin
      m_g0[k] = 0; m_g1[k] = 0; m_d0[k] = 0; m_d1[k] = 0;
      if (m_left[k] == 0) begin
        if (req0 || req1) begin
          if (req0 && req1) m_w[k] = (k == 0) ? 1 - m_last[k] : 0;
          else m_w[k] = req1 ? 1 : 0;
          m_last[k] = m_w[k];
          op = m_w[k] ? int'(op1) : int'(op0);
          a = m_w[k] ? int'(a1) : int'(a0);
          b = m_w[k] ? int'(b1) : int'(b0);
          m_pend[k] = ref_res(op, a, b);
          m_pz[k] = m_pend[k] == 0;
          m_pc[k] = ref_cout(op, a, b);
          m_left[k] = 2;
          if (m_w[k] == 1) m_g1[k] = 1; else m_g0[k] = 1;
        end
      end else if (m_left[k] == 2) begin
        m_left[k] = 1;
        m_res[k] = m_pend[k];
        m_z[k] = m_pz[k];
        m_c[k] = m_pc[k];
        if (m_w[k] == 1) m_d1[k] = 1; else m_d0[k] = 1;
      end else m_left[k] = 0;
    end
  endtask

  initial begin
    vecs[0] = '{0, 3'd0, 4'hA, 4'h3, 4'h0, 1, 0};
    vecs[1] = '{0, 3'd1, 4'hA, 4'h3, 4'h9, 0, 1};
    vecs[2] = '{0, 3'd2, 4'hA, 4'h3, 4'h7, 0, 0};
    vecs[3] = '{0, 3'd3, 4'hA, 4'h3, 4'hD, 0, 0};
    vecs[4] = '{0, 3'd4, 4'hA, 4'h3, 4'h9, 0, 0};
    vecs[5] = '{0, 3'd5, 4'hA, 4'h3, 4'hB, 0, 0};
    vecs[6] = '{0, 3'd6, 4'hA, 4'h3, 4'h2, 0, 0};
    vecs[7] = '{0, 3'd7, 4'hA, 4'h3, 4'hF, 0, 0};
    vecs[8] = '{1, 3'd3, 4'hF, 4'hF, 4'hE, 0, 1};
    vecs[9] = '{1, 3'd2, 4'h3, 4'h3, 4'h0, 1, 0};

    #2;
    chk("reset_outputs", {f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_result, f_zero, f_cout}, 16'h0);
    tick();
    rst = 1'b0;

    // single request: grant at +1, done at +2, busy for two cycles
    req0 = 1'b1; op0 = 3'd3; a0 = 4'hA; b0 = 4'h3;
    tick();
    chk("single_gnt0", {f_gnt0, f_gnt1, f_done0, f_busy}, 16'b1001);
    req0 = 1'b0;
    tick();
    chk("single_done0", {f_gnt0, f_done0, f_done1, f_busy}, 16'b0101);
    chk("single_result", f_result, 16'hD);
    chk("single_flags", {f_zero, f_cout}, 16'b00);
    tick();
    chk("single_idle", {f_busy, f_done0, f_result}, {2'b00, 4'hD});

    // table: opcode sweep on requester 0, wrap/flag cases on requester 1
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].sel) begin req1 = 1'b1; op1 = vecs[i].op; a1 = vecs[i].a; b1 = vecs[i].b; end
      else begin req0 = 1'b1; op0 = vecs[i].op; a0 = vecs[i].a; b0 = vecs[i].b; end
      tick();
      chk($sformatf("vec%0d_gnt", i), {f_gnt0, f_gnt1}, vecs[i].sel ? 16'b01 : 16'b10);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      chk($sformatf("vec%0d_done", i), {f_done0, f_done1}, vecs[i].sel ? 16'b01 : 16'b10);
      chk($sformatf("vec%0d_result", i), f_result, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), {f_zero, f_cout}, FLAGS ? {vecs[i].z, vecs[i].c} : 2'b00);
      tick();
    end

    // tie handling: fresh reset so the pointer favours req0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; op0 = 3'd3; a0 = 4'h1; b0 = 4'h1;
    req1 = 1'b1; op1 = 3'd4; a1 = 4'h5; b1 = 4'h3;
    tick();
    chk("rr_g1", {f_gnt0, f_gnt1, x_gnt0, x_gnt1}, 16'b1010);
    tick();
    chk("rr_g1_results", {f_result, x_result}, {4'h2, 4'h2});
    tick();
    chk("rr_gap", {f_gnt0, f_gnt1, f_busy}, 16'b000);
    tick();
    chk("rr_g2", {f_gnt0, f_gnt1, x_gnt0, x_gnt1}, 16'b0110);
    tick();
    chk("rr_g2_results", {f_result, x_result}, {4'h6, 4'h2});
    tick();
    tick();
    chk("rr_g3", {f_gnt0, f_gnt1, x_gnt0, x_gnt1}, 16'b1010);
    req0 = 1'b0;
    tick(); tick(); tick();
    chk("fixed_after_drop", {f_gnt0, f_gnt1, x_gnt0, x_gnt1}, 16'b0101);
    req1 = 1'b0;
    tick(); tick();

    // reset during EXEC: immediate clear, no done, re-arbitration afterwards
    req1 = 1'b1; op1 = 3'd4; a1 = 4'h5; b1 = 4'h3;
    tick();
    chk("rx_exec", {f_gnt1, f_busy}, 16'b11);
    #2 rst = 1'b1;
    #1 chk("rx_async_clear", {f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_result, f_zero, f_cout}, 16'h0);
    tick();
    chk("rx_no_done", {f_done1, f_busy, x_done1}, 16'b000);
    rst = 1'b0;
    tick();
    chk("rx_regrant", {f_gnt1, f_busy}, 16'b11);
    req1 = 1'b0;
    tick();
    chk("rx_done", {f_done1, f_result}, {1'b1, 4'h6});
    tick();

    // randomized traffic against the transaction model, both arbitration modes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!req0 || f_gnt0) begin
        req0 = 1'($urandom_range(0, 1)); op0 = 3'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
      end
      if (!req1 || f_gnt1) begin
        req1 = 1'($urandom_range(0, 1)); op1 = 3'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      end
      model_step();
      tick();
      chk("rand_fair", {f_gnt0, f_gnt1, f_done0, f_done1, f_busy, f_result, f_zero, f_cout},
          {m_g0[0], m_g1[0], m_d0[0], m_d1[0], m_left[0] != 0, 4'(m_res[0]), FLAGS & m_z[0], FLAGS & m_c[0]});
      chk("rand_fixed", {x_gnt0, x_gnt1, x_done0, x_done1, x_busy, x_result, x_zero, x_cout},
          {m_g0[1], m_g1[1], m_d0[1], m_d1[1], m_left[1] != 0, 4'(m_res[1]), FLAGS & m_z[1], FLAGS & m_c[1]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
